// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared widths, MEM-stage FSM states and forwarding-select codes.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The youngest producer (EX/MEM) takes priority over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic                  mem_ok,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    if (mem_ok && (mem_rd != '0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_unit
// Brief    : Combinational ForwardA/ForwardB select generation for EX muxes.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_unit
  import riscv_pkg::*;
(
  input  logic                  ex_mem_valid,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memtoreg,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  mem_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  logic w_mem_ok;

  // A load in EX/MEM has no data yet, so it cannot feed the EX mux.
  assign w_mem_ok  = ex_mem_valid & ex_mem_regwrite & ~ex_mem_memtoreg;
  assign forward_a = fwd_sel(w_mem_ok, ex_mem_rd, mem_wb_regwrite, mem_wb_rd, id_ex_rs1);
  assign forward_b = fwd_sel(w_mem_ok, ex_mem_rd, mem_wb_regwrite, mem_wb_rd, id_ex_rs2);

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : RV64 MEM stage (dmem handshake, branch resolve) + MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [XLEN-1:0]       ex_mem_alu,
  input  logic [XLEN-1:0]       ex_mem_store_data,
  input  logic                  ex_mem_zero,
  input  logic [XLEN-1:0]       ex_mem_branch_target,
  input  logic                  ex_mem_branch,
  input  logic                  ex_mem_memread,
  input  logic                  ex_mem_memwrite,
  input  logic                  ex_mem_regwrite,
  input  logic                  ex_mem_memtoreg,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_stall,
  output logic                  pc_src,
  output logic [XLEN-1:0]       branch_target,
  output logic [REG_ADDR_W-1:0] mem_wb_rd,
  output logic                  mem_wb_regwrite,
  output logic [XLEN-1:0]       mem_wb_data,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  misalign_err
);

  mem_state_t            r_state;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_regwrite;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_misalign_err;

  logic w_mem_op;
  logic w_misalign;
  logic w_req;
  logic w_complete;
  logic w_mis_drop;

  always_comb begin
    w_mem_op   = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);
    w_misalign = (ex_mem_alu[2:0] != 3'b000);
    w_req      = 1'b0;
    w_complete = 1'b0;
    w_mis_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misalign) begin
            w_mis_drop = 1'b1;
            w_complete = 1'b1;
          end else begin
            w_req      = 1'b1;
            w_complete = dmem_gnt & ex_mem_memwrite;
          end
        end else begin
          w_complete = ex_mem_valid;
        end
      end
      REQ: begin
        w_req      = 1'b1;
        w_complete = dmem_gnt & ex_mem_memwrite;
      end
      WAIT_RSP: w_complete = dmem_rvalid;
      default: w_complete = 1'b0;
    endcase
  end

  assign dmem_req      = w_req;
  assign dmem_we       = ex_mem_memwrite;
  assign dmem_addr     = ex_mem_alu;
  assign dmem_wdata    = ex_mem_store_data;
  assign mem_stall     = w_mem_op & ~w_complete;
  assign pc_src        = ex_mem_valid & ex_mem_branch & ex_mem_zero;
  assign branch_target = ex_mem_branch_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_wb_data      <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_mis_drop;

      case (r_state)
        IDLE, REQ: begin
          if (w_req && dmem_gnt)
            r_state <= ex_mem_memwrite ? IDLE : WAIT_RSP;
          else if (w_req)
            r_state <= REQ;
        end
        WAIT_RSP: if (dmem_rvalid) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase

      // Stalled, empty or misaligned slots become bubbles; data is left as-is.
      if (w_complete && !w_mis_drop) begin
        r_wb_rd       <= ex_mem_rd;
        r_wb_regwrite <= ex_mem_regwrite & ex_mem_valid;
        r_wb_data     <= ex_mem_memtoreg ? dmem_rdata : ex_mem_alu;
      end else begin
        r_wb_rd       <= '0;
        r_wb_regwrite <= 1'b0;
      end
    end
  end

  assign mem_wb_rd       = r_wb_rd;
  assign mem_wb_regwrite = r_wb_regwrite;
  assign mem_wb_data     = r_wb_data;
  assign misalign_err    = r_misalign_err;

  forwarding_unit u_fwd (
    .ex_mem_valid    (ex_mem_valid),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_memtoreg (ex_mem_memtoreg),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (r_wb_regwrite),
    .mem_wb_rd       (r_wb_rd),
    .id_ex_rs1       (id_ex_rs1),
    .id_ex_rs2       (id_ex_rs2),
    .forward_a       (forward_a),
    .forward_b       (forward_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Directed self-checking bench for mem_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [4:0]  ex_mem_rd;
  logic [63:0] ex_mem_alu;
  logic [63:0] ex_mem_store_data;
  logic        ex_mem_zero;
  logic [63:0] ex_mem_branch_target;
  logic        ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_regwrite, ex_mem_memtoreg;
  logic [4:0]  id_ex_rs1, id_ex_rs2;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        mem_stall, pc_src;
  logic [63:0] branch_target;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [63:0] mem_wb_data;
  logic [1:0]  forward_a, forward_b;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_alu(ex_mem_alu),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_zero(ex_mem_zero),
    .ex_mem_branch_target(ex_mem_branch_target), .ex_mem_branch(ex_mem_branch),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_data(mem_wb_data),
    .forward_a(forward_a), .forward_b(forward_b), .misalign_err(misalign_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_mem_valid = 0; ex_mem_rd = 0; ex_mem_alu = 0; ex_mem_store_data = 0;
    ex_mem_zero = 0; ex_mem_branch_target = 0; ex_mem_branch = 0;
    ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_regwrite = 0; ex_mem_memtoreg = 0;
    id_ex_rs1 = 0; id_ex_rs2 = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [63:0] addr);
    ex_mem_valid = 1; ex_mem_rd = rd; ex_mem_alu = addr;
    ex_mem_memread = 1; ex_mem_memtoreg = 1; ex_mem_regwrite = 1;
  endtask

  initial begin
    clear_ex();
    reset = 0;
    tick(); tick();
    check("rst_wb_rd", 64'(mem_wb_rd), 0);
    check("rst_wb_we", 64'(mem_wb_regwrite), 0);
    check("rst_wb_data", mem_wb_data, 0);
    check("rst_misalign", 64'(misalign_err), 0);
    check("rst_req", 64'(dmem_req), 0);
    reset = 1;
    tick();

    // ALU op
    ex_mem_valid = 1; ex_mem_rd = 5; ex_mem_alu = 64'h10; ex_mem_regwrite = 1;
    #1;
    check("alu_stall", 64'(mem_stall), 0);
    check("alu_req", 64'(dmem_req), 0);
    tick();
    check("alu_wb_rd", 64'(mem_wb_rd), 5);
    check("alu_wb_data", mem_wb_data, 64'h10);
    check("alu_wb_we", 64'(mem_wb_regwrite), 1);

    // Forwarding: put rd=3 into MEM/WB, keep rd=3 ALU op in EX/MEM
    ex_mem_rd = 3; ex_mem_alu = 64'h33;
    tick();
    check("fwd_setup_wb_rd", 64'(mem_wb_rd), 3);
    id_ex_rs1 = 3; id_ex_rs2 = 4;
    #1;
    check("fwd_a_mem", 64'(forward_a), 2'b10);
    check("fwd_b_none", 64'(forward_b), 2'b00);
    ex_mem_rd = 0; id_ex_rs1 = 0;
    #1;
    check("fwd_a_x0", 64'(forward_a), 2'b00);
    ex_mem_rd = 3; id_ex_rs1 = 3; ex_mem_memtoreg = 1;
    #1;
    check("fwd_a_load_wb", 64'(forward_a), 2'b01);
    id_ex_rs2 = 3; ex_mem_memtoreg = 0;
    #1;
    check("fwd_b_mem", 64'(forward_b), 2'b10);
    clear_ex();
    tick();
    check("bubble_we", 64'(mem_wb_regwrite), 0);
    check("bubble_rd", 64'(mem_wb_rd), 0);
    check("bubble_data_held", mem_wb_data, 64'h33);

    // Branch
    ex_mem_valid = 1; ex_mem_branch = 1; ex_mem_zero = 1; ex_mem_branch_target = 64'h40;
    #1;
    check("br_taken", 64'(pc_src), 1);
    check("br_target", branch_target, 64'h40);
    ex_mem_zero = 0;
    #1;
    check("br_not_taken", 64'(pc_src), 0);
    clear_ex();
    tick();

    // Load: no gnt for 2 cycles, gnt in 3rd, rvalid in 4th
    load(7, 64'h100);
    #1;
    check("ld_req_c1", 64'(dmem_req), 1);
    check("ld_we", 64'(dmem_we), 0);
    check("ld_addr", dmem_addr, 64'h100);
    check("ld_stall_c1", 64'(mem_stall), 1);
    tick();
    check("ld_bubble_c1", 64'(mem_wb_regwrite), 0);
    check("ld_req_c2", 64'(dmem_req), 1);
    check("ld_stall_c2", 64'(mem_stall), 1);
    tick();
    dmem_gnt = 1;
    #1;
    check("ld_stall_c3", 64'(mem_stall), 1);
    tick();
    check("ld_bubble_c3", 64'(mem_wb_regwrite), 0);
    dmem_gnt = 0;
    #1;
    check("ld_wait_req", 64'(dmem_req), 0);
    check("ld_wait_stall", 64'(mem_stall), 1);
    dmem_rvalid = 1; dmem_rdata = 64'hDEAD;
    #1;
    check("ld_rvalid_stall", 64'(mem_stall), 0);
    tick();
    check("ld_wb_data", mem_wb_data, 64'hDEAD);
    check("ld_wb_rd", 64'(mem_wb_rd), 7);
    check("ld_wb_we", 64'(mem_wb_regwrite), 1);
    clear_ex();

    // Store with immediate grant
    ex_mem_valid = 1; ex_mem_memwrite = 1; ex_mem_alu = 64'h08; ex_mem_store_data = 64'h55;
    dmem_gnt = 1;
    #1;
    check("st_req", 64'(dmem_req), 1);
    check("st_we", 64'(dmem_we), 1);
    check("st_wdata", dmem_wdata, 64'h55);
    check("st_addr", dmem_addr, 64'h08);
    check("st_stall", 64'(mem_stall), 0);
    tick();
    check("st_wb_we", 64'(mem_wb_regwrite), 0);
    clear_ex();
    #1;
    check("st_back_idle", 64'(dmem_req), 0);

    // Misaligned load
    load(9, 64'h103);
    #1;
    check("mis_req", 64'(dmem_req), 0);
    check("mis_stall", 64'(mem_stall), 0);
    check("mis_err_pre", 64'(misalign_err), 0);
    tick();
    check("mis_err", 64'(misalign_err), 1);
    check("mis_wb_we", 64'(mem_wb_regwrite), 0);
    clear_ex();
    tick();
    check("mis_err_pulse", 64'(misalign_err), 0);

    // Reset while waiting for load data
    load(10, 64'h200);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    #1;
    check("rw_wait_req", 64'(dmem_req), 0);
    reset = 0;
    #1;
    check("rw_idle_req", 64'(dmem_req), 1);
    check("rw_wb_data", mem_wb_data, 0);
    clear_ex();
    tick();
    reset = 1;
    dmem_rvalid = 1; dmem_rdata = 64'hBEEF;
    tick();
    check("late_rvalid_we", 64'(mem_wb_regwrite), 0);
    check("late_rvalid_data", mem_wb_data, 0);
    dmem_rvalid = 0;
    load(11, 64'h300);
    #1;
    check("post_rst_req", 64'(dmem_req), 1);
    clear_ex();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
